// File: rtl/sram_rd_stream.sv
// Read-address to read-data streamer for a 1-cycle-latency SRAM, with a
// 3-entry skid FIFO, credit-based a_ready, and a sticky frame-protocol checker.
module sram_rd_stream #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_first,
  input  logic          a_last,
  input  logic          a_valid,
  output logic          a_ready,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] d_data,
  output logic          d_first,
  output logic          d_last,
  output logic          d_valid,
  input  logic          d_ready,
  output logic          err,
  input  logic          err_clr,
  output logic [15:0]   frame_cnt
);

  localparam int DEPTH = 3;

  logic [1:0]    r_count;
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic          r_inflight;
  logic          r_first_q;
  logic          r_last_q;
  logic          r_in_frame;
  logic          r_err;
  logic [15:0]   r_frame_cnt;

  logic [DW-1:0] r_buf_data  [DEPTH];
  logic          r_buf_first [DEPTH];
  logic          r_buf_last  [DEPTH];

  logic [2:0]    w_occupancy;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_proto_err;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Beats in the FIFO plus the one whose SRAM read is in flight: a credit
  // count built only from registers, so a_ready never depends on d_ready.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  assign a_ready     = rst_n & (w_occupancy < 3'd3);
  assign w_accept    = a_valid & a_ready;
  assign mem_cs      = w_accept;
  assign mem_addr    = a_addr;

  assign w_push      = r_inflight;
  assign d_valid     = (r_count != 2'd0);
  assign w_pop       = d_valid & d_ready;
  assign d_data      = r_buf_data[r_rd_ptr];
  assign d_first     = r_buf_first[r_rd_ptr];
  assign d_last      = r_buf_last[r_rd_ptr];

  assign w_proto_err = w_accept & (a_first ? r_in_frame : ~r_in_frame);
  assign err         = r_err;
  assign frame_cnt   = r_frame_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_first_q  <= 1'b0;
      r_last_q   <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_first_q <= a_first;
        r_last_q  <= a_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; r_count gates
  // every read through d_valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_wr_ptr]  <= mem_rdata;
      r_buf_first[r_wr_ptr] <= r_first_q;
      r_buf_last[r_wr_ptr]  <= r_last_q;
    end
  end

  // A new error wins over a simultaneous clear so no violation is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_frame <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_proto_err | (r_err & ~err_clr);
      if (w_accept) begin
        if (a_last)       r_in_frame <= 1'b0;
        else if (a_first) r_in_frame <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_pop && d_last && (r_frame_cnt != 16'hFFFF)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

endmodule
